// File: rtl/srv32_pkg.sv
// Shared types for the srv32 data-memory arbiter.
//   req_id_e   : requester identity (core / XIF coprocessor)
//   wr_state_e : write-channel arbitration state
//   rd_state_e : read-channel arbitration state
// Both state enums share one encoding so a single channel FSM serves either.
package srv32_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_XIF  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_C    = 2'd1,
        W_X    = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_C    = 2'd1,
        R_X    = 2'd2
    } rd_state_e;

endpackage

// File: rtl/srv32_arb_chan.sv
// One arbitration channel (used for both the write and the read channel).
// Decides the owner combinationally, locks it until acceptance, and picks
// the follow-on owner after an accepted transfer.
//
// Macro DMEM_ARB_RR_EN: defined -> round-robin tie break with a per-channel
// pointer; undefined -> fixed priority, core wins ties.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   req_c_i     : core request on this channel
//   req_x_i     : XIF request on this channel
//   mvalid_i    : memory-side valid (acceptance when an owner exists)
//   active_o    : an owner exists this cycle (drives m_*ready)
//   owner_o     : current owner, meaningful only while active_o
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no lock; arbitrate among current requests
// C     | core holds the channel until its transfer is accepted
// X     | XIF holds the channel until its transfer is accepted
module srv32_arb_chan
    import srv32_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    req_c_i,
    input  logic    req_x_i,
    input  logic    mvalid_i,
    output logic    active_o,
    output req_id_e owner_o
);

    // Read-channel states mirror these encodings (R_IDLE/R_C/R_X).
    localparam logic [1:0] ST_IDLE = W_IDLE;
    localparam logic [1:0] ST_C    = W_C;
    localparam logic [1:0] ST_X    = W_X;

    logic [1:0] state_q, state_d;
    logic       accept;
    logic       other_pend;
    logic       tie_x;
    logic       other_wins;
    req_id_e    other_id;

    assign accept     = active_o & mvalid_i;
    assign other_id   = (owner_o == REQ_CORE) ? REQ_XIF : REQ_CORE;
    assign other_pend = (owner_o == REQ_CORE) ? req_x_i : req_c_i;

`ifdef DMEM_ARB_RR_EN
    req_id_e ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= REQ_CORE;
        else        ptr_q <= ptr_d;
    end

    assign ptr_d      = accept ? other_id : ptr_q;
    assign tie_x      = (ptr_q == REQ_XIF);
    // The pointer always moves to the loser, so a pending loser wins next.
    assign other_wins = 1'b1;
`else
    assign tie_x      = 1'b0;
    assign other_wins = (owner_o == REQ_XIF);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        if (accept) begin
            if (other_pend && other_wins)
                state_d = (other_id == REQ_XIF) ? ST_X : ST_C;
        end else if (active_o) begin
            state_d = (owner_o == REQ_XIF) ? ST_X : ST_C;
        end
    end

    // A locked owner that dropped its request behaves as IDLE: no transfer,
    // arbitration falls through to the current requests.
    always_comb begin
        active_o = 1'b0;
        owner_o  = REQ_CORE;
        if (rst_n) begin
            if (state_q == ST_C && req_c_i) begin
                active_o = 1'b1;
                owner_o  = REQ_CORE;
            end else if (state_q == ST_X && req_x_i) begin
                active_o = 1'b1;
                owner_o  = REQ_XIF;
            end else if (req_c_i && req_x_i) begin
                active_o = 1'b1;
                owner_o  = tie_x ? REQ_XIF : REQ_CORE;
            end else if (req_c_i) begin
                active_o = 1'b1;
                owner_o  = REQ_CORE;
            end else if (req_x_i) begin
                active_o = 1'b1;
                owner_o  = REQ_XIF;
            end
        end
    end

endmodule

// File: rtl/srv32_dmem_arbiter.sv
// Data-memory arbiter between the srv32 core (c_*) and the XIF coprocessor
// (x_*). Write and read channels are arbitrated independently; read data
// returns one cycle after acceptance to the owner captured at acceptance.
//
// Macro DMEM_ARB_RR_EN: round-robin tie break when defined, fixed core
// priority otherwise (applied inside srv32_arb_chan).
//
// Ports: clk, resetb (async active-low); per requester n in {c,x}:
//   n_wready/n_waddr/n_wdata/n_wstrb in, n_wvalid out,
//   n_rready/n_raddr in, n_rvalid/n_rresp/n_rdata out;
// memory side: m_wready/m_waddr/m_wdata/m_wstrb out, m_wvalid in,
//   m_rready/m_raddr out, m_rvalid/m_rresp/m_rdata in.
module srv32_dmem_arbiter
    import srv32_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            c_wready,
    input  logic [AW-1:0]   c_waddr,
    input  logic [DW-1:0]   c_wdata,
    input  logic [DW/8-1:0] c_wstrb,
    output logic            c_wvalid,
    input  logic            c_rready,
    input  logic [AW-1:0]   c_raddr,
    output logic            c_rvalid,
    output logic            c_rresp,
    output logic [DW-1:0]   c_rdata,
    input  logic            x_wready,
    input  logic [AW-1:0]   x_waddr,
    input  logic [DW-1:0]   x_wdata,
    input  logic [DW/8-1:0] x_wstrb,
    output logic            x_wvalid,
    input  logic            x_rready,
    input  logic [AW-1:0]   x_raddr,
    output logic            x_rvalid,
    output logic            x_rresp,
    output logic [DW-1:0]   x_rdata,
    output logic            m_wready,
    input  logic            m_wvalid,
    output logic [AW-1:0]   m_waddr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_rready,
    input  logic            m_rvalid,
    output logic [AW-1:0]   m_raddr,
    input  logic            m_rresp,
    input  logic [DW-1:0]   m_rdata
);

    logic    w_act, r_act;
    req_id_e w_owner, r_owner;
    logic    rd_pend_q, rd_pend_d;
    req_id_e rd_owner_q, rd_owner_d;
    logic    ret_c, ret_x;

    srv32_arb_chan u_wr_chan (
        .clk      (clk),
        .rst_n    (resetb),
        .req_c_i  (c_wready),
        .req_x_i  (x_wready),
        .mvalid_i (m_wvalid),
        .active_o (w_act),
        .owner_o  (w_owner)
    );

    srv32_arb_chan u_rd_chan (
        .clk      (clk),
        .rst_n    (resetb),
        .req_c_i  (c_rready),
        .req_x_i  (x_rready),
        .mvalid_i (m_rvalid),
        .active_o (r_act),
        .owner_o  (r_owner)
    );

    // Idle channels drive zero on the memory side rather than a stale mux.
    assign m_wready = w_act;
    assign m_waddr  = !w_act ? '0 : (w_owner == REQ_XIF) ? x_waddr : c_waddr;
    assign m_wdata  = !w_act ? '0 : (w_owner == REQ_XIF) ? x_wdata : c_wdata;
    assign m_wstrb  = !w_act ? '0 : (w_owner == REQ_XIF) ? x_wstrb : c_wstrb;
    assign c_wvalid = w_act & m_wvalid & (w_owner == REQ_CORE);
    assign x_wvalid = w_act & m_wvalid & (w_owner == REQ_XIF);

    assign m_rready = r_act;
    assign m_raddr  = !r_act ? '0 : (r_owner == REQ_XIF) ? x_raddr : c_raddr;
    assign c_rvalid = r_act & m_rvalid & (r_owner == REQ_CORE);
    assign x_rvalid = r_act & m_rvalid & (r_owner == REQ_XIF);

    assign rd_pend_d  = r_act & m_rvalid;
    assign rd_owner_d = rd_pend_d ? r_owner : rd_owner_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_CORE;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ret_c   = rd_pend_q & (rd_owner_q == REQ_CORE);
    assign ret_x   = rd_pend_q & (rd_owner_q == REQ_XIF);
    assign c_rresp = ret_c & m_rresp;
    assign x_rresp = ret_x & m_rresp;
    assign c_rdata = ret_c ? m_rdata : '0;
    assign x_rdata = ret_x ? m_rdata : '0;

endmodule

// File: tb/tb_srv32_dmem_arbiter.sv
module tb_srv32_dmem_arbiter;

    logic        clk = 1'b0;
    logic        resetb;
    logic        c_wready, x_wready, c_rready, x_rready;
    logic [31:0] c_waddr, c_wdata, x_waddr, x_wdata, c_raddr, x_raddr;
    logic [3:0]  c_wstrb, x_wstrb;
    logic        c_wvalid, x_wvalid, c_rvalid, x_rvalid, c_rresp, x_rresp;
    logic [31:0] c_rdata, x_rdata;
    logic        m_wready, m_wvalid, m_rready, m_rvalid, m_rresp;
    logic [31:0] m_waddr, m_wdata, m_raddr, m_rdata;
    logic [3:0]  m_wstrb;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    srv32_dmem_arbiter dut (
        .clk(clk), .resetb(resetb),
        .c_wready(c_wready), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
        .c_wvalid(c_wvalid), .c_rready(c_rready), .c_raddr(c_raddr),
        .c_rvalid(c_rvalid), .c_rresp(c_rresp), .c_rdata(c_rdata),
        .x_wready(x_wready), .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wstrb(x_wstrb),
        .x_wvalid(x_wvalid), .x_rready(x_rready), .x_raddr(x_raddr),
        .x_rvalid(x_rvalid), .x_rresp(x_rresp), .x_rdata(x_rdata),
        .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rready(m_rready), .m_rvalid(m_rvalid), .m_raddr(m_raddr),
        .m_rresp(m_rresp), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        c_wready = 0; c_waddr = 0; c_wdata = 0; c_wstrb = 0;
        x_wready = 0; x_waddr = 0; x_wdata = 0; x_wstrb = 0;
        c_rready = 0; c_raddr = 0; x_rready = 0; x_raddr = 0;
        m_wvalid = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
    endtask

    // Advance to the next negedge: inputs change there, checks follow #1.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    logic exp_x;

    initial begin
        set_idle();
        resetb = 1'b0;

        // Reset: requests present, every output must still be zero.
        next_cyc();
        c_wready = 1; c_waddr = 32'h44; m_wvalid = 1;
        x_rready = 1; x_raddr = 32'h88; m_rvalid = 1; m_rresp = 1; m_rdata = 32'h1234;
        #1;
        chk("rst_m_wready", m_wready, 0);
        chk("rst_m_waddr",  m_waddr, 0);
        chk("rst_c_wvalid", c_wvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_x_rvalid", x_rvalid, 0);
        chk("rst_x_rresp",  x_rresp, 0);
        chk("rst_x_rdata",  x_rdata, 0);
        set_idle();
        next_cyc();
        resetb = 1'b1;
        next_cyc();

        // Single core write, accepted in the request cycle.
        c_wready = 1; c_waddr = 32'h8000_0010; c_wdata = 32'hDEADBEEF; c_wstrb = 4'hF;
        m_wvalid = 1;
        #1;
        chk("wr_m_wready", m_wready, 1);
        chk("wr_m_waddr",  m_waddr, 32'h8000_0010);
        chk("wr_m_wdata",  m_wdata, 32'hDEADBEEF);
        chk("wr_m_wstrb",  m_wstrb, 4'hF);
        chk("wr_c_wvalid", c_wvalid, 1);
        chk("wr_x_wvalid", x_wvalid, 0);
        next_cyc();
        set_idle();

        // Simultaneous reads for 4 cycles: RR alternates, fixed stays on core.
        c_rready = 1; c_raddr = 32'h200; x_rready = 1; x_raddr = 32'h300;
        m_rvalid = 1; m_rresp = 1;
        for (int i = 0; i < 4; i++) begin
            m_rdata = 32'hA000_0000 + i;
            #1;
`ifdef DMEM_ARB_RR_EN
            exp_x = (i % 2) == 1;
`else
            exp_x = 1'b0;
`endif
            chk($sformatf("tie%0d_c_rvalid", i), c_rvalid, !exp_x);
            chk($sformatf("tie%0d_x_rvalid", i), x_rvalid, exp_x);
            chk($sformatf("tie%0d_m_raddr", i), m_raddr, exp_x ? 32'h300 : 32'h200);
            if (i > 0) begin
`ifdef DMEM_ARB_RR_EN
                exp_x = (i % 2) == 0;
`endif
                chk($sformatf("tie%0d_ret_c_rresp", i), c_rresp, !exp_x);
                chk($sformatf("tie%0d_ret_x_rresp", i), x_rresp, exp_x);
                chk($sformatf("tie%0d_ret_data", i), exp_x ? x_rdata : c_rdata, 32'hA000_0000 + i);
            end
            next_cyc();
        end
        set_idle();
        m_rresp = 1; m_rdata = 32'hBBBB_0003;
`ifdef DMEM_ARB_RR_EN
        exp_x = 1'b1;
`else
        exp_x = 1'b0;
`endif
        #1;
        chk("tie_last_x_rresp", x_rresp, exp_x);
        chk("tie_last_c_rresp", c_rresp, !exp_x);
        next_cyc();
        set_idle();

        // XIF read locked while m_rvalid low; core arrives mid-request.
        x_rready = 1; x_raddr = 32'h100; m_rresp = 1; m_rdata = 32'h7777;
        #1;
        chk("lock0_m_raddr", m_raddr, 32'h100);
        chk("lock0_x_rvalid", x_rvalid, 0);
        next_cyc();
        c_rready = 1; c_raddr = 32'h200;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk($sformatf("lock%0d_m_raddr", i), m_raddr, 32'h100);
            chk($sformatf("lock%0d_c_rvalid", i), c_rvalid, 0);
            chk($sformatf("lock%0d_x_rresp", i), x_rresp, 0);
            next_cyc();
        end
        m_rvalid = 1;
        #1;
        chk("lock3_x_rvalid", x_rvalid, 1);
        chk("lock3_c_rvalid", c_rvalid, 0);
        next_cyc();
        x_rready = 0; m_rdata = 32'h5555_AAAA;
        #1;
        chk("lock4_x_rdata", x_rdata, 32'h5555_AAAA);
        chk("lock4_x_rresp", x_rresp, 1);
        chk("lock4_c_rdata", c_rdata, 0);
        chk("lock4_c_rvalid", c_rvalid, 1);
        chk("lock4_m_raddr", m_raddr, 32'h200);
        next_cyc();
        c_rready = 0; m_rvalid = 0; m_rdata = 32'h1234_5678;
        #1;
        chk("lock5_c_rdata", c_rdata, 32'h1234_5678);
        chk("lock5_x_rdata", x_rdata, 0);
        next_cyc();
        set_idle();

        // Owner drops its write before acceptance: no transfer issued.
        c_wready = 1; c_waddr = 32'hC0;
        #1;
        chk("drop0_m_waddr", m_waddr, 32'hC0);
        next_cyc();
        c_wready = 0; m_wvalid = 1;
        #1;
        chk("drop1_m_wready", m_wready, 0);
        chk("drop1_c_wvalid", c_wvalid, 0);
        next_cyc();
        x_wready = 1; x_waddr = 32'hD0; x_wdata = 32'h55; x_wstrb = 4'h1;
        #1;
        chk("drop2_x_wvalid", x_wvalid, 1);
        chk("drop2_m_waddr", m_waddr, 32'hD0);
        chk("drop2_m_wstrb", m_wstrb, 4'h1);
        chk("drop2_c_wvalid", c_wvalid, 0);
        next_cyc();
        set_idle();

        // Core write and XIF read accepted in the same cycle.
        c_wready = 1; c_waddr = 32'h10; c_wdata = 32'h11; c_wstrb = 4'h3; m_wvalid = 1;
        x_rready = 1; x_raddr = 32'h20; m_rvalid = 1;
        #1;
        chk("dual_c_wvalid", c_wvalid, 1);
        chk("dual_x_rvalid", x_rvalid, 1);
        chk("dual_c_rvalid", c_rvalid, 0);
        chk("dual_m_raddr", m_raddr, 32'h20);
        chk("dual_m_wdata", m_wdata, 32'h11);
        next_cyc();
        set_idle();
        m_rresp = 1; m_rdata = 32'hCAFE_F00D;
        #1;
        chk("dual_x_rresp", x_rresp, 1);
        chk("dual_x_rdata", x_rdata, 32'hCAFE_F00D);
        chk("dual_c_rresp", c_rresp, 0);
        next_cyc();
        set_idle();

        // Core read accepted, then reset: return must be dropped.
        c_rready = 1; c_raddr = 32'h40; m_rvalid = 1;
        #1;
        chk("rr_c_rvalid", c_rvalid, 1);
        next_cyc();
        resetb = 0; m_rresp = 1; m_rdata = 32'hFFFF;
        c_wready = 1; c_waddr = 32'h99; m_wvalid = 1;
        #1;
        chk("rr_rst_c_rresp", c_rresp, 0);
        chk("rr_rst_c_rdata", c_rdata, 0);
        chk("rr_rst_m_rready", m_rready, 0);
        chk("rr_rst_m_raddr", m_raddr, 0);
        chk("rr_rst_c_rvalid", c_rvalid, 0);
        chk("rr_rst_m_wready", m_wready, 0);
        chk("rr_rst_m_waddr", m_waddr, 0);
        next_cyc();
        resetb = 1; set_idle(); m_rresp = 1; m_rdata = 32'hFFFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("rr_post%0d_c_rresp", i), c_rresp, 0);
            chk($sformatf("rr_post%0d_c_rdata", i), c_rdata, 0);
            chk($sformatf("rr_post%0d_m_rready", i), m_rready, 0);
            next_cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/srv32_dmem_arbiter.md
SRV32_DMEM_ARBITER -- requirements
Module: srv32_dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width; strobe width is DW/8.
REQ-003 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-004 SHALL have port resetb, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have per requester n in {c (core), x (XIF coprocessor)}:
- write request: n_wready in 1, n_waddr in AW, n_wdata in DW, n_wstrb in DW/8.
- write grant: n_wvalid out 1.
- read request: n_rready in 1, n_raddr in AW.
- read grant: n_rvalid out 1.
- read return: n_rresp out 1, n_rdata out DW.
REQ-006 SHALL have memory-side ports:
- m_wready out 1, m_wvalid in 1, m_waddr out AW, m_wdata out DW, m_wstrb out DW/8.
- m_rready out 1, m_rvalid in 1, m_raddr out AW, m_rresp in 1, m_rdata in DW.

Function
REQ-007 SHALL arbitrate the write and read channels independently, each with its own FSM: W_IDLE/W_C/W_X and R_IDLE/R_C/R_X.
REQ-008 SHALL treat a transfer as accepted in the cycle where m_*ready and m_*valid are both high; the grant goes to the owner combinationally in that cycle (n_*valid = m_*valid AND owner==n).
REQ-009 SHALL, from IDLE with one request, enter that requester's state in the same cycle (combinational grant, zero added latency); memory-side outputs mux from the owner.
REQ-010 SHALL, with simultaneous requests in IDLE, grant per the priority rule of REQ-019.
REQ-011 SHALL hold ownership (lock) while the owner's request is high and not yet accepted; the other requester is never granted mid-request.
REQ-012 SHALL, after an accepted transfer, return to IDLE, or go directly to the other requester's state if it is pending; back-to-back single-cycle transfers are supported.
REQ-013 SHALL, if the owner drops its request before acceptance, return to IDLE without issuing a transfer.
REQ-014 SHALL capture the read owner in rd_owner_q on read acceptance and set rd_pend_q; the next cycle m_rdata/m_rresp are routed to that owner's n_rdata/n_rresp.
REQ-015 SHALL drive the non-owner's n_rresp low and n_rdata zero.
REQ-016 SHALL keep n_*valid low for any requester not asserting n_*ready.
REQ-017 SHALL allow a write and a read to be accepted in the same cycle, including by different requesters.

Reset
REQ-018 SHALL, while resetb is low, set both FSMs to IDLE, rd_pend_q=0, rd_owner_q=core, rr pointers=core, and drive all outputs 0; an in-flight transfer is dropped, with no return routed after reset release.

Configuration
REQ-019 SHALL use macro DMEM_ARB_RR_EN.
- Defined: round-robin per channel; the pointer toggles to the non-winner after each accepted transfer; ties go to the pointer.
- Undefined: fixed priority, core always wins ties; pointer logic absent.

Structure
REQ-020 SHALL place the FSM state enums (wr_state_e, rd_state_e) and the requester-ID enum (REQ_CORE=0, REQ_XIF=1) in the shared package srv32_pkg.
REQ-021 SHALL implement one sub-module, srv32_arb_chan, instantiated twice (write, read), holding the FSM, lock and pointer logic; the read-return register stays in the top level.

Verification
REQ-022 Core write 0x8000_0010, data 0xDEADBEEF, strb 0xF, m_wvalid=1 -> same cycle m_waddr=0x8000_0010, c_wvalid=1, x_wvalid=0.
REQ-023 Simultaneous core and XIF reads, m_rvalid=1 for 4 cycles -> with RR_EN grants C,X,C,X; without RR_EN C,C,C,C.
REQ-024 XIF read 0x100 while m_rvalid is held low 3 cycles, core read arrives in cycle 1 -> x stays owner; core is granted only after x acceptance; x_rdata = m_rdata one cycle after acceptance.
REQ-025 Core read accepted, resetb pulled low the next cycle -> all outputs 0, FSMs IDLE; after release, no stale c_rresp.
REQ-026 Core write and XIF read requested in the same cycle, both m_*valid=1 -> both accepted that cycle; x_rresp one cycle later.
